spi_arb_master: RTL and testbench

SPI_ARB_MASTER -- requirements
Module: spi_arb_master

---
 rtl/spi_arb_master.sv | 151 +++++++++++++++
 tb/tb_spi_arb_master.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_arb_master.sv
// SPI master shared by four requesters through a round-robin arbiter.
// Each transfer moves one byte in either direction, in any of the four SPI modes.
module spi_arb_master #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] tx_data,
  input  logic        cpol,
  input  logic        cpha,
  output logic [3:0]  grant,
  output logic        done,
  output logic [7:0]  rx_data,
  output logic        busy,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic [3:0]  ss_n,
  output logic [2:0]  dbg_state
);

  // Handshake: req[i] is a level request sampled only in IDLE; the one-hot
  // grant acknowledges it, and the single-cycle done pulse closes the transfer.
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD, S_GAP} state_t;

  localparam logic [7:0] LP_DIV_M1 = 8'(CLK_DIV - 1);

  state_t      r_state, w_next;
  logic [7:0]  r_cnt;
  logic [4:0]  r_edge;
  logic [1:0]  r_ptr, r_win;
  logic [7:0]  r_sh_tx, r_sh_rx, r_rx_data;
  logic [3:0]  r_grant, r_ss_n;
  logic        r_cpol, r_cpha, r_sclk, r_mosi, r_done;
  logic [1:0]  w_win;
  logic        w_half_end, w_lead, w_last_edge, w_sample;

  function automatic logic [1:0] rr_pick(input logic [1:0] p, input logic [3:0] r);
    logic [1:0] k;
    rr_pick = p;
    for (int i = 3; i >= 0; i--) begin
      k = p + 2'(i);
      if (r[k]) rr_pick = k;
    end
  endfunction

  assign w_win       = rr_pick(r_ptr, req);
  assign w_half_end  = (r_cnt == LP_DIV_M1);
  // r_edge counts edges already made, so an even count means the next edge leads.
  assign w_lead      = ~r_edge[0];
  assign w_last_edge = (r_edge == 5'd15);
  assign w_sample    = w_lead ^ r_cpha;

  always_ff @(posedge clk) begin : state_reg
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin : next_state
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (|req) w_next = S_SETUP;
      S_SETUP: if (w_half_end) w_next = S_XFER;
      S_XFER:  if (w_half_end && w_last_edge) w_next = S_HOLD;
      S_HOLD:  if (w_half_end) w_next = S_GAP;
      S_GAP:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin : datapath
    if (!rst) begin
      r_cnt     <= '0;
      r_edge    <= '0;
      r_ptr     <= '0;
      r_win     <= '0;
      r_sh_tx   <= '0;
      r_sh_rx   <= '0;
      r_rx_data <= '0;
      r_grant   <= '0;
      r_ss_n    <= 4'hF;
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt  <= '0;
          r_edge <= '0;
          if (|req) begin
            r_win   <= w_win;
            r_grant <= 4'b0001 << w_win;
            r_ss_n  <= ~(4'b0001 << w_win);
            r_sh_tx <= tx_data[{w_win, 3'b000} +: 8];
            r_sh_rx <= '0;
            r_cpol  <= cpol;
            r_cpha  <= cpha;
            r_sclk  <= cpol;
            r_mosi  <= cpha ? 1'b0 : tx_data[{w_win, 3'b111}];
          end
        end
        S_SETUP: r_cnt <= w_half_end ? 8'd0 : r_cnt + 8'd1;
        S_XFER: begin
          if (w_half_end) begin
            r_cnt  <= '0;
            r_sclk <= ~r_sclk;
            r_edge <= r_edge + 5'd1;
            if (w_sample) begin
              r_sh_rx <= {r_sh_rx[6:0], miso};
            end else if (!w_last_edge) begin
              // cpha=0 already presented bit 7 at grant, so it drives the following bit.
              r_mosi  <= r_cpha ? r_sh_tx[7] : r_sh_tx[6];
              r_sh_tx <= {r_sh_tx[6:0], 1'b0};
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_HOLD: begin
          if (w_half_end) begin
            r_cnt     <= '0;
            r_ss_n    <= 4'hF;
            r_grant   <= '0;
            r_rx_data <= r_sh_rx;
            r_done    <= 1'b1;
            r_ptr     <= r_win + 2'd1;
            r_mosi    <= 1'b0;
            r_sclk    <= r_cpol;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign grant     = r_grant;
  assign done      = r_done;
  assign rx_data   = r_rx_data;
  assign busy      = (r_state != S_IDLE);
  assign sclk      = r_sclk;
  assign mosi      = r_mosi;
  assign ss_n      = r_ss_n;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_spi_arb_master.sv
// Bench for spi_arb_master: an SPI slave model and a round-robin model predict
// winner, timing and data; two extra instances cover the CLK_DIV extremes.
`timescale 1ns/1ps
module tb_spi_arb_master;

  localparam int D  = 4;
  localparam int DB = 2;
  localparam int DC = 255;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [3:0]  req, req_b, req_c;
  logic [31:0] tx_data;
  logic        cpol, cpha;
  logic        miso = 1'b0;

  logic [3:0] grant, ss_n, grant_b, ss_n_b, grant_c, ss_n_c;
  logic       done, busy, sclk, mosi, done_b, busy_b, sclk_b, mosi_b, done_c, busy_c, sclk_c, mosi_c;
  logic [7:0] rx_data, rx_data_b, rx_data_c;
  logic [2:0] dbg_state, dbg_state_b, dbg_state_c;

  spi_arb_master #(.CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .req(req), .tx_data(tx_data), .cpol(cpol), .cpha(cpha),
    .grant(grant), .done(done), .rx_data(rx_data), .busy(busy), .sclk(sclk),
    .mosi(mosi), .miso(miso), .ss_n(ss_n), .dbg_state(dbg_state));

  spi_arb_master #(.CLK_DIV(DB)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .tx_data(tx_data), .cpol(cpol), .cpha(cpha),
    .grant(grant_b), .done(done_b), .rx_data(rx_data_b), .busy(busy_b), .sclk(sclk_b),
    .mosi(mosi_b), .miso(miso), .ss_n(ss_n_b), .dbg_state(dbg_state_b));

  spi_arb_master #(.CLK_DIV(DC)) dut_c (
    .clk(clk), .rst(rst), .req(req_c), .tx_data(tx_data), .cpol(cpol), .cpha(cpha),
    .grant(grant_c), .done(done_c), .rx_data(rx_data_c), .busy(busy_c), .sclk(sclk_c),
    .mosi(mosi_c), .miso(miso), .ss_n(ss_n_c), .dbg_state(dbg_state_c));

  // scoreboard counters
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: round-robin pointer plus arithmetic search
  logic [1:0] m_ptr = 2'd0;

  function automatic int rr(input logic [1:0] p, input logic [3:0] r);
    for (int i = 0; i < 4; i++)
      if (r[(int'(p) + i) % 4]) return (int'(p) + i) % 4;
    return int'(p);
  endfunction

  function automatic logic ss_ok(input logic [3:0] s, input logic [3:0] g);
    logic [3:0] lo;
    lo = ~s;
    return $onehot0(lo) && (lo == g);
  endfunction

  // SPI slave model: samples mosi and drives miso on the mode's edges
  logic       mode_cpol = 1'b0, mode_cpha = 1'b0;
  logic [7:0] slv_tx = 8'h00, slv_sh = 8'h00, slv_got = 8'h00;
  int         slv_edges = 0, slv_lead = 0;
  logic       slv_active = 1'b0, prev_sclk = 1'b0;

  always @(negedge clk) begin
    logic lead;
    if (ss_n === 4'hF || $isunknown(ss_n)) begin
      slv_active = 1'b0;
      slv_edges  = 0;
      slv_lead   = 0;
      slv_got    = 8'h00;
      prev_sclk  = sclk;
      miso       = 1'b0;
    end else if (!slv_active) begin
      slv_active = 1'b1;
      prev_sclk  = sclk;
      slv_sh     = slv_tx;
      if (!mode_cpha) begin
        miso   = slv_sh[7];
        slv_sh = {slv_sh[6:0], 1'b0};
      end
    end else if (sclk !== prev_sclk) begin
      prev_sclk = sclk;
      slv_edges++;
      lead = (sclk !== mode_cpol);
      if (lead) slv_lead++;
      if (lead != mode_cpha) begin
        slv_got = {slv_got[6:0], mosi};
      end else begin
        miso   = slv_sh[7];
        slv_sh = {slv_sh[6:0], 1'b0};
      end
    end
  end

  // select invariant on all instances
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      check("ss_inv_a", ss_ok(ss_n, grant), 1);
      check("ss_inv_b", ss_ok(ss_n_b, grant_b), 1);
      check("ss_inv_c", ss_ok(ss_n_c, grant_c), 1);
    end
  end

  // driver: one full transfer, called and returning in an IDLE cycle
  task automatic run_xfer(input logic [3:0] rq, input logic [31:0] txd, input logic pol,
                          input logic pha, input logic [7:0] sb, input int drop_edge,
                          input logic keep, output int won);
    int         w, cyc;
    logic       got_done;
    logic [3:0] oh, ex_ss;
    logic [7:0] eb;
    w     = rr(m_ptr, rq);
    oh    = 4'b0001 << w;
    ex_ss = ~oh;
    eb    = txd[8*w +: 8];
    mode_cpol = pol; mode_cpha = pha; slv_tx = sb;
    req = rq; tx_data = txd; cpol = pol; cpha = pha;
    @(posedge clk); #1;
    check("grant", grant, oh);
    check("ss_n_sel", ss_n, ex_ss);
    check("sclk_setup", sclk, pol);
    check("busy_xfer", busy, 1);
    if (!keep) req = 4'b0000;
    tx_data = $urandom; cpol = ~pol; cpha = ~pha;
    got_done = 1'b0; cyc = 0;
    for (int c = 1; c <= 18*D + 4; c++) begin
      @(posedge clk); #1;
      if (drop_edge > 0 && slv_edges >= drop_edge) req[w] = 1'b0;
      if (done === 1'b1) begin cyc = c; got_done = 1'b1; break; end
    end
    check("done_seen", got_done, 1);
    check("xfer_len", cyc, 18*D);
    check("rx_data", rx_data, sb);
    check("mosi_bits", slv_got, eb);
    check("edge_count", slv_edges, 16);
    check("lead_count", slv_lead, 8);
    check("ss_n_gap", ss_n, 4'hF);
    check("grant_gap", grant, 0);
    check("busy_gap", busy, 1);
    m_ptr = 2'(w + 1);
    @(posedge clk); #1;
    check("done_width", done, 0);
    check("busy_idle", busy, 0);
    check("ss_n_idle", ss_n, 4'hF);
    check("sclk_idle", sclk, pol);
    check("mosi_idle", mosi, 0);
    won = w;
  endtask

  int won, n, cyc;
  logic prev, seen;
  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b0; req = 0; req_b = 0; req_c = 0; tx_data = 0; cpol = 0; cpha = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", grant, 0);
    check("rst_ss_n", ss_n, 4'hF);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_rx", rx_data, 0);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    rst = 1'b1; m_ptr = 2'd0;
    @(posedge clk); #1;

    // mode 0 directed byte exchange
    run_xfer(4'b0010, 32'h0000_A500, 1'b0, 1'b0, 8'h3C, 0, 1'b0, won);
    check("mode0_winner", won, 1);
    // modes 1..3
    run_xfer(4'b0001, {4{8'h5A}}, 1'b0, 1'b1, 8'hC3, 0, 1'b0, won);
    run_xfer(4'b0100, {4{8'h5A}}, 1'b1, 1'b0, 8'hC3, 0, 1'b0, won);
    run_xfer(4'b1000, {4{8'h5A}}, 1'b1, 1'b1, 8'hC3, 0, 1'b0, won);

    // randomized requests, modes and data
    for (int k = 0; k < 8; k++)
      run_xfer(4'($urandom_range(1, 15)), $urandom, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 8'($urandom_range(1, 255)), 0, 1'b0, won);

    // request withdrawn mid-transfer still completes and advances the pointer
    run_xfer(4'b0100, 32'h00C6_0000, 1'b0, 1'b0, 8'h96, 5, 1'b1, won);
    check("drop_winner", won, 2);
    run_xfer(4'b1011, 32'h7E00_0000, 1'b0, 1'b1, 8'h69, 0, 1'b0, won);
    check("after_drop_winner", won, 3);

    // reset at the ninth SCLK edge aborts the transfer
    mode_cpol = 0; mode_cpha = 0; slv_tx = 8'h81;
    req = 4'b0001; tx_data = 32'h0000_00F0; cpol = 0; cpha = 0;
    @(posedge clk); #1;
    req = 0;
    check("abort_grant", grant, 4'b0001);
    for (int c = 0; c < 20*D; c++) begin
      @(negedge clk); #1;
      if (slv_edges >= 9) break;
    end
    check("abort_edge9", slv_edges, 9);
    check("abort_sclk_pre", sclk, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_ss_n", ss_n, 4'hF);
    check("abort_grant0", grant, 0);
    check("abort_sclk", sclk, 0);
    check("abort_rx", rx_data, 0);
    check("abort_busy", busy, 0);
    rst = 1'b1; m_ptr = 2'd0;
    seen = 1'b0;
    for (int c = 0; c < 3*D; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    check("abort_no_done", seen, 0);

    // all requesters held: rotation starts at 0 after reset
    for (int k = 0; k < 5; k++) begin
      run_xfer(4'b1111, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               8'($urandom_range(0, 255)), 0, 1'b1, won);
      check("rr_order", won, order[k]);
    end
    req = 4'b0000;
    @(posedge clk); #1;

    // CLK_DIV = 2 half-period
    cpol = 0; cpha = 0;
    req_b = 4'b0100;
    @(posedge clk); #1;
    req_b = 0;
    prev = sclk_b;
    for (int c = 0; c < 4*DB + 4; c++) begin
      @(posedge clk); #1;
      if (sclk_b !== prev) break;
    end
    prev = sclk_b; n = 0;
    for (int c = 0; c < 2*DB + 4; c++) begin
      @(posedge clk); #1; n++;
      if (sclk_b !== prev) break;
    end
    check("half_period_2", n, DB);
    seen = 1'b0;
    for (int c = 0; c < 18*DB + 4; c++) begin
      @(posedge clk); #1;
      if (done_b === 1'b1) begin seen = 1'b1; break; end
    end
    check("done_div2", seen, 1);

    // CLK_DIV = 255 half-period and full length
    req_c = 4'b0010;
    @(posedge clk); #1;
    req_c = 0;
    prev = sclk_c;
    for (int c = 0; c < 4*DC + 4; c++) begin
      @(posedge clk); #1;
      if (sclk_c !== prev) break;
    end
    prev = sclk_c; n = 0;
    for (int c = 0; c < 2*DC + 4; c++) begin
      @(posedge clk); #1; n++;
      if (sclk_c !== prev) break;
    end
    check("half_period_255", n, DC);
    seen = 1'b0; cyc = 0;
    for (int c = 0; c < 18*DC + 4; c++) begin
      @(posedge clk); #1;
      if (done_c === 1'b1) begin seen = 1'b1; break; end
    end
    check("done_div255", seen, 1);
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
